// File: rtl/sb_result_collector.sv
// Collects solver samples, tracks the minimum-energy spin configuration and streams
// a 4-word result packet (energy, step, spins, sample count) once the solver reports done.
module sb_result_collector #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         valid_in,
  input  logic [N-1:0]                 spins_in,
  input  logic signed [DATA_WIDTH-1:0] energy_in,
  input  logic [31:0]                  step_in,
  input  logic                         done_in,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] best_energy,
  output logic [N-1:0]                 best_spins,
  output logic [31:0]                  best_step,
  output logic [31:0]                  sample_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last
);

  if (N < 1 || N > DATA_WIDTH) begin : g_bad_params
    $error("sb_result_collector: N must satisfy 1 <= N <= DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  localparam logic [DATA_WIDTH-1:0]        ONES   = '1;
  localparam logic signed [DATA_WIDTH-1:0] E_MAX  = signed'(ONES >> 1);
  localparam logic [31:0]                  STEP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fit_word(input logic [31:0] v);
    logic [DATA_WIDTH+31:0] wide;
    wide = {{DATA_WIDTH{1'b0}}, v};
    return wide[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fit_spins(input logic [N-1:0] v);
    logic [DATA_WIDTH+N-1:0] wide;
    wide = {{DATA_WIDTH{1'b0}}, v};
    return wide[DATA_WIDTH-1:0];
  endfunction

  state_t     state, state_nxt;
  logic [1:0] word_idx, word_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= 2'd0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_nxt;
    end
  end

  // start aborts from any state; a handshake coinciding with start is discarded
  always_comb begin
    state_nxt = state;
    word_nxt  = word_idx;
    if (start) begin
      state_nxt = COLLECT;
      word_nxt  = 2'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (done_in) begin
            state_nxt = DRAIN;
            word_nxt  = 2'd0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (word_idx == 2'd3) state_nxt = IDLE;
            word_nxt = word_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Best-sample tracker: strict less-than keeps the earliest of equal energies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_energy  <= E_MAX;
      best_spins   <= '0;
      best_step    <= STEP_RST;
      sample_count <= 32'd0;
    end else if (start) begin
      best_energy  <= E_MAX;
      best_spins   <= '0;
      best_step    <= STEP_RST;
      sample_count <= 32'd0;
    end else if (state == COLLECT && valid_in) begin
      sample_count <= sat_inc(sample_count);
      if (sample_count == 32'd0 || energy_in < best_energy) begin
        best_energy <= energy_in;
        best_spins  <= spins_in;
        best_step   <= step_in;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (word_idx == 2'd3);

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      case (word_idx)
        2'd0:    out_data = best_energy;
        2'd1:    out_data = fit_word(best_step);
        2'd2:    out_data = fit_spins(best_spins);
        default: out_data = fit_word(sample_count);
      endcase
    end
  end

endmodule

// File: tb/tb_sb_result_collector.sv
// Directed bench for sb_result_collector: stimulus queues expected packet words,
// a negedge monitor compares every presented word and pops on handshake.
module tb_sb_result_collector;
  localparam int N  = 8;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 valid_in;
  logic [N-1:0]         spins_in;
  logic signed [DW-1:0] energy_in;
  logic [31:0]          step_in;
  logic                 done_in;
  logic                 busy;
  logic signed [DW-1:0] best_energy;
  logic [N-1:0]         best_spins;
  logic [31:0]          best_step;
  logic [31:0]          sample_count;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 out_last;

  sb_result_collector #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
    .spins_in(spins_in), .energy_in(energy_in), .step_in(step_in),
    .done_in(done_in), .busy(busy), .best_energy(best_energy),
    .best_spins(best_spins), .best_step(best_step),
    .sample_count(sample_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic push_pkt(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    exp_q.push_back('{data: w0, last: 1'b0});
    exp_q.push_back('{data: w1, last: 1'b0});
    exp_q.push_back('{data: w2, last: 1'b0});
    exp_q.push_back('{data: w3, last: 1'b1});
  endtask

  // Monitor: every presented word must match the queue head; pop only on handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
      end else begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input int e, input logic [31:0] st, input logic [N-1:0] sp,
                        input logic dn);
    valid_in  = 1'b1;
    energy_in = e;
    step_in   = st;
    spins_in  = sp;
    done_in   = dn;
    tick();
    valid_in  = 1'b0;
    done_in   = 1'b0;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 50) begin
      tick();
      cyc++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected idle", name, cyc);
    end
    tick();
  endtask

  initial begin
    int cyc;
    int vcycles;
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; spins_in = '0;
    energy_in = '0; step_in = '0; done_in = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_busy",         32'(busy),         32'd0);
    chk("rst_out_valid",    32'(out_valid),    32'd0);
    chk("rst_out_last",     32'(out_last),     32'd0);
    chk("rst_out_data",     out_data,          32'd0);
    chk("rst_best_energy",  best_energy,       32'h7FFF_FFFF);
    chk("rst_best_step",    best_step,         32'hFFFF_FFFF);
    chk("rst_best_spins",   32'(best_spins),   32'd0);
    chk("rst_sample_count", sample_count,      32'd0);
    rst_n = 1'b1;
    tick();

    // T1: reset asserted while a packet is stalled in DRAIN
    push_pkt(32'd9, 32'd3, 32'h09, 32'd1);
    pulse_start();
    sample(9, 32'd3, 8'h09, 1'b0);
    pulse_done();
    chk("t1_busy_drain", 32'(busy), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid",   32'(out_valid), 32'd0);
    chk("t1_best_energy", best_energy,    32'h7FFF_FFFF);
    chk("t1_best_step",   best_step,      32'hFFFF_FFFF);
    chk("t1_busy",        32'(busy),      32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // T2: minimum tracking with an equal-energy repeat
    out_ready = 1'b1;
    push_pkt(32'hFFFF_FFF6, 32'd5, 32'h15, 32'd5);
    pulse_start();
    sample(5,   32'd1, 8'h11, 1'b0);
    chk("t2_first_energy", best_energy, 32'd5);
    sample(-3,  32'd2, 8'h12, 1'b0);
    sample(-3,  32'd3, 8'h13, 1'b0);
    chk("t2_tie_step", best_step, 32'd2);
    sample(7,   32'd4, 8'h14, 1'b0);
    sample(-10, 32'd5, 8'h15, 1'b0);
    chk("t2_best_energy",  best_energy,     32'hFFFF_FFF6);
    chk("t2_best_spins",   32'(best_spins), 32'h15);
    chk("t2_sample_count", sample_count,    32'd5);
    pulse_done();
    wait_idle("t2");
    chk("t2_hold_count", sample_count, 32'd5);

    // T3: tie plus sample in the same cycle as done
    push_pkt(32'hFFFF_FFFE, 32'd1, 32'h21, 32'd2);
    pulse_start();
    sample(-2, 32'd1, 8'h21, 1'b0);
    sample(-2, 32'd2, 8'h22, 1'b1);
    chk("t3_best_step",    best_step,    32'd1);
    chk("t3_sample_count", sample_count, 32'd2);
    wait_idle("t3");

    // T4: out_ready toggling every cycle
    out_ready = 1'b0;
    push_pkt(32'd50, 32'd11, 32'hA1, 32'd2);
    pulse_start();
    sample(100, 32'd10, 8'hA0, 1'b0);
    sample(50,  32'd11, 8'hA1, 1'b0);
    pulse_done();
    cyc = 0;
    vcycles = 0;
    while (busy && cyc < 40) begin
      out_ready = (cyc % 2 == 0);
      if (out_valid) vcycles++;
      tick();
      cyc++;
    end
    chk("t4_packet_cycles_ok", 32'(vcycles >= 7 && vcycles <= 8), 32'd1);
    chk("t4_queue_drained",    32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    tick();

    // T5: done with no samples sends reset values
    push_pkt(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    pulse_start();
    pulse_done();
    wait_idle("t5");

    // T6: abort during DRAIN after word 1 has been accepted
    push_pkt(32'd1, 32'd1, 32'h31, 32'd2);
    pulse_start();
    sample(1, 32'd1, 8'h31, 1'b0);
    sample(2, 32'd2, 8'h32, 1'b0);
    pulse_done();
    tick();
    tick();
    out_ready = 1'b0;
    pulse_start();
    chk("t6_out_valid",    32'(out_valid), 32'd0);
    chk("t6_busy",         32'(busy),      32'd1);
    chk("t6_sample_count", sample_count,   32'd0);
    chk("t6_best_energy",  best_energy,    32'h7FFF_FFFF);
    exp_q.delete();
    out_ready = 1'b1;
    push_pkt(32'd4, 32'd7, 32'h44, 32'd1);
    sample(4, 32'd7, 8'h44, 1'b0);
    pulse_done();
    wait_idle("t6");

    // Samples outside COLLECT are ignored
    sample(-50, 32'd9, 8'hFF, 1'b1);
    chk("idle_ignore_count",  sample_count, 32'd1);
    chk("idle_ignore_energy", best_energy,  32'd4);
    chk("idle_no_packet",     32'(busy),    32'd0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
